// File: rtl/trap_hdlr_pkg.sv
// Shared definitions for the trap handler: privilege codes, CSR addresses, mstatus layout, FSM states.
// S-mode support is compiled in only when TRAP_SMODE_EN is defined.
package trap_hdlr_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned IM_ADDR_LEN = 32;

`ifdef TRAP_SMODE_EN
    localparam bit SmodeEn = 1'b1;
`else
    localparam bit SmodeEn = 1'b0;
`endif

    localparam logic [1:0] PRV_U = 2'b00;
    localparam logic [1:0] PRV_S = 2'b01;
    localparam logic [1:0] PRV_M = 2'b11;

    localparam logic [11:0] CSR_SSTATUS = 12'h100;
    localparam logic [11:0] CSR_STVEC   = 12'h105;
    localparam logic [11:0] CSR_SEPC    = 12'h141;
    localparam logic [11:0] CSR_SCAUSE  = 12'h142;
    localparam logic [11:0] CSR_STVAL   = 12'h143;
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEDELEG = 12'h302;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;

    localparam int unsigned EXC_ECALL_U = 8;
    localparam int unsigned EXC_ECALL_S = 9;
    localparam int unsigned EXC_ECALL_M = 11;

    localparam int unsigned MSTATUS_SIE    = 1;
    localparam int unsigned MSTATUS_MIE    = 3;
    localparam int unsigned MSTATUS_SPIE   = 5;
    localparam int unsigned MSTATUS_MPIE   = 7;
    localparam int unsigned MSTATUS_SPP    = 8;
    localparam int unsigned MSTATUS_MPP_LO = 11;
    localparam int unsigned MSTATUS_MPP_HI = 12;
    localparam int unsigned MSTATUS_TVM    = 20;

    typedef logic [0:0] trap_state_t;
    localparam trap_state_t StIdle  = 1'b0;
    localparam trap_state_t StRedir = 1'b1;

    // Software-writable mstatus fields, extracted from a CSR write.
    typedef struct packed {
        logic       mie;
        logic       mpie;
        logic       sie;
        logic       spie;
        logic       spp;
        logic [1:0] mpp;
        logic       tvm;
    } status_wr_t;

    // Unsupported privilege encodings collapse to U.
    function automatic logic [1:0] legal_prv(input logic [1:0] p);
        if (p == PRV_M) return PRV_M;
        if (p == PRV_S && SmodeEn) return PRV_S;
        return PRV_U;
    endfunction

endpackage

// File: rtl/trap_status_stk.sv
// mstatus/sstatus interrupt-enable and privilege stack plus current privilege level.
// Push on trap entry, pop on xRET; S-mode fields exist only with TRAP_SMODE_EN.
module trap_status_stk
    import trap_hdlr_pkg::*;
#(
    parameter int unsigned XLEN_P = XLEN
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              push,
    input  logic              push_deleg,
    input  logic              pop_m,
    input  logic              pop_s,
    input  logic              mstatus_wen,
    input  logic              sstatus_wen,
    input  status_wr_t        wr,
    output logic [XLEN_P-1:0] mstatus,
    output logic [1:0]        prv_cur,
    output logic              tvm
);

    logic       mie_q, mpie_q, sie_q, spie_q, spp_q, tvm_q;
    logic       mie_d, mpie_d, sie_d, spie_d, spp_d, tvm_d;
    logic [1:0] mpp_q, prv_q;
    logic [1:0] mpp_d, prv_d;

    always_comb begin
        mie_d  = mie_q;
        mpie_d = mpie_q;
        sie_d  = sie_q;
        spie_d = spie_q;
        spp_d  = spp_q;
        mpp_d  = mpp_q;
        tvm_d  = tvm_q;
        prv_d  = prv_q;
        if (push) begin
            if (push_deleg) begin
                spie_d = sie_q;
                sie_d  = 1'b0;
                spp_d  = (prv_q == PRV_S);
                prv_d  = PRV_S;
            end else begin
                mpie_d = mie_q;
                mie_d  = 1'b0;
                mpp_d  = prv_q;
                prv_d  = PRV_M;
            end
        end else if (pop_m) begin
            mie_d  = mpie_q;
            mpie_d = 1'b1;
            prv_d  = mpp_q;
            mpp_d  = PRV_U;
        end else if (pop_s) begin
            sie_d  = spie_q;
            spie_d = 1'b1;
            prv_d  = spp_q ? PRV_S : PRV_U;
            spp_d  = 1'b0;
        end else if (mstatus_wen) begin
            mie_d  = wr.mie;
            mpie_d = wr.mpie;
            sie_d  = SmodeEn & wr.sie;
            spie_d = SmodeEn & wr.spie;
            spp_d  = SmodeEn & wr.spp;
            mpp_d  = legal_prv(wr.mpp);
            tvm_d  = wr.tvm;
        end else if (sstatus_wen) begin
            sie_d  = SmodeEn & wr.sie;
            spie_d = SmodeEn & wr.spie;
            spp_d  = SmodeEn & wr.spp;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            mie_q  <= 1'b0;
            mpie_q <= 1'b0;
            sie_q  <= 1'b0;
            spie_q <= 1'b0;
            spp_q  <= 1'b0;
            tvm_q  <= 1'b0;
            mpp_q  <= PRV_U;
            prv_q  <= PRV_M;
        end else begin
            mie_q  <= mie_d;
            mpie_q <= mpie_d;
            sie_q  <= sie_d;
            spie_q <= spie_d;
            spp_q  <= spp_d;
            tvm_q  <= tvm_d;
            mpp_q  <= mpp_d;
            prv_q  <= prv_d;
        end
    end

    always_comb begin
        mstatus                                = '0;
        mstatus[MSTATUS_SIE]                   = sie_q;
        mstatus[MSTATUS_MIE]                   = mie_q;
        mstatus[MSTATUS_SPIE]                  = spie_q;
        mstatus[MSTATUS_MPIE]                  = mpie_q;
        mstatus[MSTATUS_SPP]                   = spp_q;
        mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = mpp_q;
        mstatus[MSTATUS_TVM]                   = tvm_q;
    end

    assign prv_cur = prv_q;
    assign tvm     = tvm_q;

endmodule

// File: rtl/trap_hdlr.sv
// Trap/xRET consumer: commits trap CSRs and privilege, then issues a PC redirect over valid/ready.
// Define TRAP_SMODE_EN to build S-mode CSRs, delegation and sret.
module trap_hdlr
    import trap_hdlr_pkg::*;
#(
    parameter int unsigned       XLEN_P = XLEN,
    parameter logic [XLEN_P-1:0] RST_PC = '0
) (
    input  logic                   clk,
    input  logic                   srst,
    input  logic                   trap_en,
    input  logic [XLEN_P-1:0]      trap_cause,
    input  logic [IM_ADDR_LEN-1:0] trap_epc,
    input  logic [XLEN_P-1:0]      trap_val,
    input  logic                   mret,
    input  logic                   sret,
    input  logic                   csr_wen,
    input  logic [11:0]            csr_waddr,
    input  logic [XLEN_P-1:0]      csr_wdata,
    input  logic [11:0]            csr_raddr,
    output logic [XLEN_P-1:0]      csr_rdata,
    output logic [1:0]             prv_cur,
    output logic                   tvm,
    output logic                   redirect_valid,
    output logic [IM_ADDR_LEN-1:0] redirect_pc,
    input  logic                   redirect_ready,
    output logic                   busy
);

    localparam logic [15:0] MEDELEG_MASK = ~(16'd1 << EXC_ECALL_M);
    localparam logic [XLEN_P-1:0] SSTATUS_MASK =
        XLEN_P'((1 << MSTATUS_SIE) | (1 << MSTATUS_SPIE) | (1 << MSTATUS_SPP));

    trap_state_t       state_q, state_d;
    logic [15:0]       medeleg_q;
    logic [XLEN_P-1:0] mtvec_q, mepc_q, mcause_q, mtval_q;
    logic [XLEN_P-1:0] stvec_q, sepc_q, scause_q, stval_q;
    logic [XLEN_P-1:0] mstatus, target;
    logic [IM_ADDR_LEN-1:0] redirect_pc_q;
    logic              idle, trap_fire, mret_fire, sret_fire, ev, deleg, trap_m, trap_s;
    logic              wr_mstatus, wr_sstatus, wr_medeleg, wr_mtvec, wr_stvec;
    logic              wr_mepc, wr_mcause, wr_mtval, wr_sepc, wr_scause, wr_stval;
    status_wr_t        status_wr;

    // Events are only taken in idle; priority trap > mret > sret.
    assign idle      = (state_q == StIdle);
    assign trap_fire = idle && trap_en;
    assign mret_fire = idle && !trap_en && mret;
    assign sret_fire = SmodeEn && idle && !trap_en && !mret && sret;
    assign ev        = trap_fire || mret_fire || sret_fire;
    assign deleg     = SmodeEn && medeleg_q[trap_cause[3:0]] && (prv_cur != PRV_M);
    assign trap_m    = trap_fire && !deleg;
    assign trap_s    = trap_fire && deleg;

    always_comb begin
        if (trap_fire) target = deleg ? stvec_q : mtvec_q;
        else if (mret_fire) target = mepc_q;
        else target = sepc_q;
    end

    assign wr_mstatus = csr_wen && (csr_waddr == CSR_MSTATUS);
    assign wr_sstatus = csr_wen && (csr_waddr == CSR_SSTATUS);
    assign wr_medeleg = csr_wen && (csr_waddr == CSR_MEDELEG);
    assign wr_mtvec   = csr_wen && (csr_waddr == CSR_MTVEC);
    assign wr_stvec   = csr_wen && (csr_waddr == CSR_STVEC);
    assign wr_mepc    = csr_wen && (csr_waddr == CSR_MEPC);
    assign wr_mcause  = csr_wen && (csr_waddr == CSR_MCAUSE);
    assign wr_mtval   = csr_wen && (csr_waddr == CSR_MTVAL);
    assign wr_sepc    = csr_wen && (csr_waddr == CSR_SEPC);
    assign wr_scause  = csr_wen && (csr_waddr == CSR_SCAUSE);
    assign wr_stval   = csr_wen && (csr_waddr == CSR_STVAL);

    assign status_wr.mie  = csr_wdata[MSTATUS_MIE];
    assign status_wr.mpie = csr_wdata[MSTATUS_MPIE];
    assign status_wr.sie  = csr_wdata[MSTATUS_SIE];
    assign status_wr.spie = csr_wdata[MSTATUS_SPIE];
    assign status_wr.spp  = csr_wdata[MSTATUS_SPP];
    assign status_wr.mpp  = csr_wdata[MSTATUS_MPP_HI:MSTATUS_MPP_LO];
    assign status_wr.tvm  = csr_wdata[MSTATUS_TVM];

    trap_status_stk #(
        .XLEN_P(XLEN_P)
    ) u_status_stk (
        .clk        (clk),
        .srst       (srst),
        .push       (trap_fire),
        .push_deleg (deleg),
        .pop_m      (mret_fire),
        .pop_s      (sret_fire),
        .mstatus_wen(wr_mstatus && !ev),
        .sstatus_wen(SmodeEn && wr_sstatus && !ev),
        .wr         (status_wr),
        .mstatus    (mstatus),
        .prv_cur    (prv_cur),
        .tvm        (tvm)
    );

    always_comb begin
        state_d = state_q;
        if (idle) begin
            if (ev) state_d = StRedir;
        end else if (redirect_ready) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_q       <= StIdle;
            redirect_pc_q <= '0;
            medeleg_q     <= '0;
            mtvec_q       <= RST_PC;
            stvec_q       <= RST_PC;
            mepc_q        <= '0;
            mcause_q      <= '0;
            mtval_q       <= '0;
            sepc_q        <= '0;
            scause_q      <= '0;
            stval_q       <= '0;
        end else begin
            state_q <= state_d;
            if (ev) redirect_pc_q <= IM_ADDR_LEN'(target);
            if (SmodeEn && wr_medeleg) medeleg_q <= csr_wdata[15:0] & MEDELEG_MASK;
            if (wr_mtvec) mtvec_q <= {csr_wdata[XLEN_P-1:2], 2'b00};
            if (SmodeEn && wr_stvec) stvec_q <= {csr_wdata[XLEN_P-1:2], 2'b00};
            // A trap's own update wins over a same-cycle software write.
            if (trap_m) begin
                mepc_q   <= XLEN_P'(trap_epc);
                mcause_q <= trap_cause;
                mtval_q  <= trap_val;
            end else begin
                if (wr_mepc) mepc_q <= {csr_wdata[XLEN_P-1:1], 1'b0};
                if (wr_mcause) mcause_q <= csr_wdata;
                if (wr_mtval) mtval_q <= csr_wdata;
            end
            if (trap_s) begin
                sepc_q   <= XLEN_P'(trap_epc);
                scause_q <= trap_cause;
                stval_q  <= trap_val;
            end else if (SmodeEn) begin
                if (wr_sepc) sepc_q <= {csr_wdata[XLEN_P-1:1], 1'b0};
                if (wr_scause) scause_q <= csr_wdata;
                if (wr_stval) stval_q <= csr_wdata;
            end
        end
    end

    always_comb begin
        csr_rdata = '0;
        case (csr_raddr)
            CSR_MSTATUS: csr_rdata = mstatus;
            CSR_SSTATUS: csr_rdata = mstatus & SSTATUS_MASK;
            CSR_MEDELEG: csr_rdata = SmodeEn ? XLEN_P'(medeleg_q) : '0;
            CSR_MTVEC:   csr_rdata = mtvec_q;
            CSR_STVEC:   csr_rdata = SmodeEn ? stvec_q : '0;
            CSR_MEPC:    csr_rdata = mepc_q;
            CSR_MCAUSE:  csr_rdata = mcause_q;
            CSR_MTVAL:   csr_rdata = mtval_q;
            CSR_SEPC:    csr_rdata = SmodeEn ? sepc_q : '0;
            CSR_SCAUSE:  csr_rdata = SmodeEn ? scause_q : '0;
            CSR_STVAL:   csr_rdata = SmodeEn ? stval_q : '0;
            default:     csr_rdata = '0;
        endcase
    end

    assign redirect_valid = (state_q == StRedir);
    assign busy           = (state_q == StRedir);
    assign redirect_pc    = redirect_pc_q;

    // The pipeline is flushed while a redirect is pending, so no new event may arrive.
    redirect_no_event_a: assert property (@(posedge clk) disable iff (srst)
        (state_q == StRedir) |-> !(trap_en || mret || sret));

endmodule

// File: tb/tb_trap_hdlr.sv
// Directed bench for trap_hdlr: a field-level model checked every cycle, plus literal pins.
// Expectations follow the build's TRAP_SMODE_EN setting.
module tb_trap_hdlr;

`ifdef TRAP_SMODE_EN
    localparam bit SM = 1'b1;
`else
    localparam bit SM = 1'b0;
`endif

    logic        clk = 1'b0, srst = 1'b1;
    logic        trap_en = 1'b0, mret = 1'b0, sret = 1'b0, csr_wen = 1'b0, redirect_ready = 1'b0;
    logic [31:0] trap_cause = '0, trap_epc = '0, trap_val = '0, csr_wdata = '0;
    logic [11:0] csr_waddr = '0, csr_raddr = 12'h300;
    logic [31:0] csr_rdata, redirect_pc;
    logic [1:0]  prv_cur;
    logic        tvm, redirect_valid, busy;

    int n_tests = 0;
    int n_fail  = 0;
    bit model_ok = 1'b0;

    always #5 clk = ~clk;

    trap_hdlr #(
        .RST_PC(32'h0)
    ) dut (
        .clk           (clk),
        .srst          (srst),
        .trap_en       (trap_en),
        .trap_cause    (trap_cause),
        .trap_epc      (trap_epc),
        .trap_val      (trap_val),
        .mret          (mret),
        .sret          (sret),
        .csr_wen       (csr_wen),
        .csr_waddr     (csr_waddr),
        .csr_wdata     (csr_wdata),
        .csr_raddr     (csr_raddr),
        .csr_rdata     (csr_rdata),
        .prv_cur       (prv_cur),
        .tvm           (tvm),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .redirect_ready(redirect_ready),
        .busy          (busy)
    );

    // Model state: architectural fields only.
    logic [1:0]  m_prv, m_mpp;
    logic        m_mie, m_mpie, m_sie, m_spie, m_spp, m_tvm;
    logic [15:0] m_medeleg;
    logic [31:0] m_mtvec, m_stvec, m_mepc, m_mcause, m_mtval, m_sepc, m_scause, m_stval;
    bit          m_pend;
    logic [31:0] m_pc;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    function automatic logic [1:0] legal(input logic [1:0] p);
        if (p == 2'd3) return 2'd3;
        if (p == 2'd1 && SM) return 2'd1;
        return 2'd0;
    endfunction

    function automatic logic [31:0] model_read(input logic [11:0] a);
        logic [31:0] st;
        st = '0;
        st[1] = m_sie;
        st[3] = m_mie;
        st[5] = m_spie;
        st[7] = m_mpie;
        st[8] = m_spp;
        st[12:11] = m_mpp;
        st[20] = m_tvm;
        case (a)
            12'h300: return st;
            12'h100: return st & 32'h0000_0122;
            12'h302: return SM ? {16'h0, m_medeleg} : 32'h0;
            12'h305: return m_mtvec;
            12'h105: return SM ? m_stvec : 32'h0;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h343: return m_mtval;
            12'h141: return SM ? m_sepc : 32'h0;
            12'h142: return SM ? m_scause : 32'h0;
            12'h143: return SM ? m_stval : 32'h0;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_write(input logic [11:0] a, input logic [31:0] d,
                               input bit ev, input bit tm, input bit ts);
        case (a)
            12'h300: if (!ev) begin
                m_mie = d[3]; m_mpie = d[7]; m_mpp = legal(d[12:11]); m_tvm = d[20];
                if (SM) begin m_sie = d[1]; m_spie = d[5]; m_spp = d[8]; end
            end
            12'h100: if (!ev && SM) begin m_sie = d[1]; m_spie = d[5]; m_spp = d[8]; end
            12'h302: if (SM) m_medeleg = d[15:0] & 16'hF7FF;
            12'h305: m_mtvec = d & 32'hFFFF_FFFC;
            12'h105: if (SM) m_stvec = d & 32'hFFFF_FFFC;
            12'h341: if (!tm) m_mepc = d & 32'hFFFF_FFFE;
            12'h342: if (!tm) m_mcause = d;
            12'h343: if (!tm) m_mtval = d;
            12'h141: if (SM && !ts) m_sepc = d & 32'hFFFF_FFFE;
            12'h142: if (SM && !ts) m_scause = d;
            12'h143: if (SM && !ts) m_stval = d;
            default: ;
        endcase
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        bit ev, tm, ts, dl;
        logic [31:0] tgt;
        ev = 0; tm = 0; ts = 0; tgt = '0;
        model_ok = 1'b1;
        if (srst) begin
            m_prv = 2'd3; m_mpp = 2'd0;
            m_mie = 0; m_mpie = 0; m_sie = 0; m_spie = 0; m_spp = 0; m_tvm = 0;
            m_medeleg = '0; m_mtvec = 32'h0; m_stvec = 32'h0;
            m_mepc = '0; m_mcause = '0; m_mtval = '0; m_sepc = '0; m_scause = '0; m_stval = '0;
            m_pend = 0; m_pc = '0;
            return;
        end
        if (!m_pend) begin
            if (trap_en) begin
                dl = SM && m_medeleg[trap_cause[3:0]] && (m_prv != 2'd3);
                ev = 1;
                if (dl) begin
                    tgt = m_stvec; ts = 1;
                    m_sepc = trap_epc; m_scause = trap_cause; m_stval = trap_val;
                    m_spie = m_sie; m_sie = 0; m_spp = (m_prv == 2'd1); m_prv = 2'd1;
                end else begin
                    tgt = m_mtvec; tm = 1;
                    m_mepc = trap_epc; m_mcause = trap_cause; m_mtval = trap_val;
                    m_mpie = m_mie; m_mie = 0; m_mpp = m_prv; m_prv = 2'd3;
                end
            end else if (mret) begin
                ev = 1; tgt = m_mepc;
                m_mie = m_mpie; m_mpie = 1; m_prv = m_mpp; m_mpp = 2'd0;
            end else if (sret && SM) begin
                ev = 1; tgt = m_sepc;
                m_sie = m_spie; m_spie = 1; m_prv = m_spp ? 2'd1 : 2'd0; m_spp = 0;
            end
        end else if (redirect_ready) begin
            m_pend = 0;
        end
        if (csr_wen) model_write(csr_waddr, csr_wdata, ev, tm, ts);
        if (ev) begin
            m_pend = 1;
            m_pc = tgt;
        end
    endtask

    always @(negedge clk) begin
        if (model_ok) begin
            check("prv_cur", 32'(prv_cur), 32'(m_prv));
            check("tvm", 32'(tvm), 32'(m_tvm));
            check("redirect_valid", 32'(redirect_valid), 32'(m_pend));
            check("busy", 32'(busy), 32'(m_pend));
            if (m_pend) check("redirect_pc", redirect_pc, m_pc);
            check("csr_rdata", csr_rdata, model_read(csr_raddr));
        end
    end

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        csr_wen = 1'b1; csr_waddr = a; csr_wdata = d;
        cycle();
        csr_wen = 1'b0;
    endtask

    task automatic do_mret();
        mret = 1'b1;
        cycle();
        mret = 1'b0;
    endtask

    task automatic do_trap(input logic [31:0] c, input logic [31:0] epc, input logic [31:0] val);
        trap_en = 1'b1; trap_cause = c; trap_epc = epc; trap_val = val;
        cycle();
        trap_en = 1'b0;
    endtask

    task automatic accept();
        redirect_ready = 1'b1;
        cycle();
        redirect_ready = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [11:0] a, input logic [31:0] exp);
        csr_raddr = a;
        #1;
        check(name, csr_rdata, exp);
    endtask

    logic [11:0] sweep [12] = '{12'h300, 12'h100, 12'h302, 12'h305, 12'h105, 12'h341,
                                12'h342, 12'h343, 12'h141, 12'h142, 12'h143, 12'h344};

    task automatic sweep_reads();
        foreach (sweep[i]) begin
            csr_raddr = sweep[i];
            cycle();
        end
        csr_raddr = 12'h300;
    endtask

    initial begin
        cycle();
        cycle();
        srst = 1'b0;
        check("rst_prv", 32'(prv_cur), 32'd3);
        check("rst_valid", 32'(redirect_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rd_chk("rst_mtvec", 12'h305, 32'h0);
        rd_chk("rst_mstatus", 12'h300, 32'h0);
        sweep_reads();

        // Drop to U via mret, then U-mode ecall.
        wr(12'h305, 32'h81);
        rd_chk("mtvec_align", 12'h305, 32'h80);
        wr(12'h341, 32'h400);
        do_mret();
        check("mret_u_pc", redirect_pc, 32'h400);
        check("mret_u_prv", 32'(prv_cur), 32'd0);
        accept();
        do_trap(32'd8, 32'h1000, 32'h0);
        check("ecall_valid", 32'(redirect_valid), 32'd1);
        check("ecall_pc", redirect_pc, 32'h80);
        check("ecall_prv", 32'(prv_cur), 32'd3);
        rd_chk("ecall_mepc", 12'h341, 32'h1000);
        rd_chk("ecall_mcause", 12'h342, 32'd8);
        accept();
        rd_chk("ecall_mstatus", 12'h300, 32'h0);

        // Delegated load page fault from S.
        wr(12'h105, 32'h200);
        wr(12'h302, 32'h2800);
        rd_chk("medeleg_ro11", 12'h302, SM ? 32'h2000 : 32'h0);
        wr(12'h300, 32'h800);
        wr(12'h341, 32'h3000);
        do_mret();
        check("mret_s_prv", 32'(prv_cur), SM ? 32'd1 : 32'd0);
        accept();
        do_trap(32'd13, 32'h3000, 32'hDEAD_0000);
        check("deleg_prv", 32'(prv_cur), SM ? 32'd1 : 32'd3);
        check("deleg_pc", redirect_pc, SM ? 32'h200 : 32'h80);
        rd_chk("deleg_stval", 12'h143, SM ? 32'hDEAD_0000 : 32'h0);
        rd_chk("deleg_sstatus", 12'h100, SM ? 32'h100 : 32'h0);
        accept();
        rd_chk("deleg_mtval", 12'h343, SM ? 32'h0 : 32'hDEAD_0000);

        // Delegated cause while in M stays in M.
        do_trap(32'd9, 32'h3100, 32'h0);
        accept();
        do_trap(32'd13, 32'h3200, 32'h1234);
        check("m_nodeleg_prv", 32'(prv_cur), 32'd3);
        check("m_nodeleg_pc", redirect_pc, 32'h80);
        rd_chk("m_nodeleg_mcause", 12'h342, 32'd13);
        accept();

        // mret with MPP=S, MPIE=1, TVM=1.
        wr(12'h300, 32'h0010_0880);
        wr(12'h341, 32'h2004);
        do_mret();
        check("mret_prv", 32'(prv_cur), SM ? 32'd1 : 32'd0);
        check("mret_pc", redirect_pc, 32'h2004);
        check("mret_tvm", 32'(tvm), 32'd1);
        rd_chk("mret_mstatus", 12'h300, 32'h0010_0088);
        accept();
        sweep_reads();

        // trap beats mret; redirect held while ready is low.
        trap_en = 1'b1; trap_cause = 32'd2; trap_epc = 32'h5000; trap_val = 32'h77; mret = 1'b1;
        cycle();
        trap_en = 1'b0; mret = 1'b0;
        check("both_prv", 32'(prv_cur), 32'd3);
        for (int i = 0; i < 3; i++) begin
            check("hold_valid", 32'(redirect_valid), 32'd1);
            check("hold_pc", redirect_pc, 32'h80);
            cycle();
        end
        accept();
        check("accept_valid", 32'(redirect_valid), 32'd0);
        rd_chk("both_mcause", 12'h342, 32'd2);

        // epc alignment, trap beats software write, reset mid-redirect.
        wr(12'h341, 32'h3003);
        rd_chk("mepc_align", 12'h341, 32'h3002);
        csr_wen = 1'b1; csr_waddr = 12'h341; csr_wdata = 32'h7777;
        do_trap(32'd5, 32'h6000, 32'h0);
        csr_wen = 1'b0;
        rd_chk("trap_wins", 12'h341, 32'h6000);
        accept();
        wr(12'h300, 32'h0);
        do_mret();
        check("pre_rst_prv", 32'(prv_cur), 32'd0);
        check("pre_rst_pc", redirect_pc, 32'h6000);
        srst = 1'b1;
        cycle();
        srst = 1'b0;
        check("srst_valid", 32'(redirect_valid), 32'd0);
        check("srst_busy", 32'(busy), 32'd0);
        check("srst_prv", 32'(prv_cur), 32'd3);
        rd_chk("srst_mepc", 12'h341, 32'h0);
        sweep_reads();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
